// File: rtl/vx_warp_ctl_recv_pkg.sv
// ============================================================================
// vx_warp_ctl_recv_pkg
// ----------------------------------------------------------------------------
// Purpose : shared sizing constants and request/entry types for the
//           scheduler-side warp-control receiver and its IPDOM stacks.
// Contents: core geometry (warps, threads, barriers, PC width), divergence
//           stack sizing, the request structs carried by the warp-control
//           interface, the IPDOM stack entry, and a popcount helper.
// Optional: WCTL_PERF_EN (used by the top level) enables perf counters whose
//           width is PERF_CTR_BITS below.
// ============================================================================

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

`ifndef NUM_BARRIERS
`define NUM_BARRIERS 4
`endif

package vx_warp_ctl_recv_pkg;

   localparam int NUM_WARPS     = `NUM_WARPS;
   localparam int NUM_THREADS   = `NUM_THREADS;
   localparam int NUM_BARRIERS  = `NUM_BARRIERS;
   localparam int PC_BITS       = 32;
   localparam int PERF_CTR_BITS = 32;

   localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
   localparam int NW_CNT_W = $clog2(NUM_WARPS + 1);

   // Each divergent split pushes two entries, so twice the thread count
   // covers the deepest possible nesting.
   localparam int DV_STACK_SIZE  = 2 * NUM_THREADS;
   localparam int DV_STACK_SIZEW = $clog2(DV_STACK_SIZE + 1);
   localparam int DV_STACK_ADDRW = (DV_STACK_SIZE > 1) ? $clog2(DV_STACK_SIZE) : 1;

   typedef struct packed {
      logic                   valid;
      logic [NUM_THREADS-1:0] tmask;
   } tmc_t;

   typedef struct packed {
      logic                 valid;
      logic [NUM_WARPS-1:0] wmask;
      logic [PC_BITS-1:0]   pc;
   } wspawn_t;

   typedef struct packed {
      logic                   valid;
      logic                   is_dvg;
      logic [NUM_THREADS-1:0] then_tmask;
      logic [NUM_THREADS-1:0] else_tmask;
      logic [PC_BITS-1:0]     next_pc;
   } split_t;

   typedef struct packed {
      logic                      valid;
      logic [DV_STACK_SIZEW-1:0] stack_ptr;
   } join_t;

   typedef struct packed {
      logic                valid;
      logic [NB_WIDTH-1:0] id;
      logic                is_global;
      logic [NW_WIDTH-1:0] size_m1;
      logic                is_noop;
   } barrier_t;

   typedef struct packed {
      logic [NUM_THREADS-1:0] tmask;
      logic [PC_BITS-1:0]     pc;
      logic                   is_else;
   } ipdom_entry_t;

   // Number of set bits in a warp-wide vector.
   function automatic logic [NW_CNT_W-1:0] count_ones(input logic [NUM_WARPS-1:0] vec);
      logic [NW_CNT_W-1:0] total;
      total = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         total = total + NW_CNT_W'(vec[i]);
      end
      return total;
   endfunction

endpackage

// File: rtl/vx_warp_ctl_recv_if.sv
// ============================================================================
// vx_warp_ctl_recv_if
// ----------------------------------------------------------------------------
// Purpose : request channel from the SFU warp-control unit to the scheduler.
// Signals : valid, wid        - request strobe and target warp
//           tmc/wspawn/split/sjoin/barrier - at most one .valid per request
//           dvstack_wid       - warp whose stack pointer is being looked up
//           dvstack_ptr       - combinational answer for dvstack_wid
// Modports: master (SFU side drives requests), slave (scheduler side).
// ============================================================================

interface vx_warp_ctl_recv_if;
   import vx_warp_ctl_recv_pkg::*;

   logic                      valid;
   logic [NW_WIDTH-1:0]       wid;
   tmc_t                      tmc;
   wspawn_t                   wspawn;
   split_t                    split;
   join_t                     sjoin;
   barrier_t                  barrier;
   logic [NW_WIDTH-1:0]       dvstack_wid;
   logic [DV_STACK_SIZEW-1:0] dvstack_ptr;

   modport master (
      output valid, wid, tmc, wspawn, split, sjoin, barrier, dvstack_wid,
      input  dvstack_ptr
   );

   modport slave (
      input  valid, wid, tmc, wspawn, split, sjoin, barrier, dvstack_wid,
      output dvstack_ptr
   );

endinterface

// File: rtl/vx_warp_ctl_recv_ipdom_stack.sv
// ============================================================================
// vx_warp_ctl_recv_ipdom_stack
// ----------------------------------------------------------------------------
// Purpose : one warp's IPDOM divergence stack. A divergent split pushes two
//           entries at once (lo then hi, hi ends on top); a join pops one.
// Ports   : clk, reset         - clock, synchronous active-high reset
//           push2              - push lo_entry and hi_entry this cycle
//           lo_entry, hi_entry - entries to push (hi_entry becomes top)
//           pop                - drop the top entry
//           top_entry          - current top of stack (undefined when empty)
//           ptr                - number of valid entries
// ============================================================================

module vx_warp_ctl_recv_ipdom_stack
   import vx_warp_ctl_recv_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push2,
   input  ipdom_entry_t              lo_entry,
   input  ipdom_entry_t              hi_entry,
   input  logic                      pop,
   output ipdom_entry_t              top_entry,
   output logic [DV_STACK_SIZEW-1:0] ptr
);

   ipdom_entry_t              entries [DV_STACK_SIZE];
   logic [DV_STACK_ADDRW-1:0] lo_idx;
   logic [DV_STACK_ADDRW-1:0] hi_idx;
   logic [DV_STACK_ADDRW-1:0] top_idx;
   logic                      push_ok;
   logic                      pop_ok;

   // The stack also refuses an overfull push or an empty pop on its own,
   // so a bad request can never corrupt the pointer.
   assign push_ok   = push2 && (ptr <= DV_STACK_SIZEW'(DV_STACK_SIZE - 2));
   assign pop_ok    = pop && !push2 && (ptr != '0);
   assign lo_idx    = ptr[DV_STACK_ADDRW-1:0];
   assign hi_idx    = lo_idx + DV_STACK_ADDRW'(1);
   assign top_idx   = DV_STACK_ADDRW'(ptr - DV_STACK_SIZEW'(1));
   assign top_entry = entries[top_idx];

   // Entry storage carries no reset: the pointer alone decides which
   // entries are meaningful.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         entries[lo_idx] <= lo_entry;
         entries[hi_idx] <= hi_entry;
      end
   end

   // Pointer moves up by two on a push, down by one on a pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (push_ok) begin
         ptr <= ptr + DV_STACK_SIZEW'(2);
      end else if (pop_ok) begin
         ptr <= ptr - DV_STACK_SIZEW'(1);
      end
   end

endmodule

// File: rtl/vx_warp_ctl_recv.sv
// ============================================================================
// vx_warp_ctl_recv
// ----------------------------------------------------------------------------
// Purpose : scheduler-side receiver of warp-control requests. Applies
//           tmc / wspawn / split / join / barrier to the per-warp state
//           (active mask, thread masks, IPDOM stacks, local barriers) and
//           emits PC redirects and spawn pulses to the scheduler.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           warp_ctl_if     - slave modport: requests in, dvstack_ptr out
//           warp_active     - active-warp mask
//           thread_masks    - per-warp thread mask
//           warp_stalled    - warps held at a barrier
//           redirect_valid/redirect_wid/redirect_pc - one-cycle resume pulse
//           spawn_valid/spawn_mask/spawn_pc         - one-cycle spawn pulse
//           dvstack_ovf     - sticky flag: divergent split on a full stack
// Optional: WCTL_PERF_EN adds perf_splits, perf_joins_redirect and
//           perf_bar_stall_cycles counters (wrap on overflow).
// ============================================================================

module vx_warp_ctl_recv
   import vx_warp_ctl_recv_pkg::*;
(
   input  logic                                    clk,
   input  logic                                    reset,
   vx_warp_ctl_recv_if.slave                       warp_ctl_if,
   output logic [NUM_WARPS-1:0]                    warp_active,
   output logic [NUM_WARPS-1:0][NUM_THREADS-1:0]   thread_masks,
   output logic [NUM_WARPS-1:0]                    warp_stalled,
   output logic                                    redirect_valid,
   output logic [NW_WIDTH-1:0]                     redirect_wid,
   output logic [PC_BITS-1:0]                      redirect_pc,
   output logic                                    spawn_valid,
   output logic [NUM_WARPS-1:0]                    spawn_mask,
   output logic [PC_BITS-1:0]                      spawn_pc,
   output logic                                    dvstack_ovf
`ifdef WCTL_PERF_EN
  ,output logic [PERF_CTR_BITS-1:0]                perf_splits
  ,output logic [PERF_CTR_BITS-1:0]                perf_joins_redirect
  ,output logic [PERF_CTR_BITS-1:0]                perf_bar_stall_cycles
`endif
);

   logic [NW_WIDTH-1:0]                   wid;
   logic [NUM_WARPS-1:0]                  spawn_bits;
   logic                                  can_push;

   logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] bar_mask;
   logic [NUM_BARRIERS-1:0][NW_WIDTH-1:0]  bar_cnt;

   logic [NUM_WARPS-1:0]                   active_n;
   logic [NUM_WARPS-1:0][NUM_THREADS-1:0]  masks_n;
   logic [NUM_WARPS-1:0]                   stalled_n;
   logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] bar_mask_n;
   logic [NUM_BARRIERS-1:0][NW_WIDTH-1:0]  bar_cnt_n;
   logic                                   redirect_valid_n;
   logic [NW_WIDTH-1:0]                    redirect_wid_n;
   logic [PC_BITS-1:0]                     redirect_pc_n;
   logic                                   spawn_valid_n;
   logic [NUM_WARPS-1:0]                   spawn_mask_n;
   logic [PC_BITS-1:0]                     spawn_pc_n;
   logic                                   ovf_n;

   logic [NUM_WARPS-1:0]                   push2;
   logic [NUM_WARPS-1:0]                   pop;
   ipdom_entry_t                           lo_entry;
   ipdom_entry_t                           hi_entry;
   ipdom_entry_t                           top_entry  [NUM_WARPS];
   logic [DV_STACK_SIZEW-1:0]              stack_ptrs [NUM_WARPS];

   assign wid        = warp_ctl_if.wid;
   // Warp 0 is always running, so a spawn never touches it.
   assign spawn_bits = warp_ctl_if.wspawn.wmask & ~NUM_WARPS'(1);
   assign can_push   = stack_ptrs[wid] <= DV_STACK_SIZEW'(DV_STACK_SIZE - 2);

   // A divergent split saves the pre-split mask underneath and the else
   // branch on top, so the first join runs the else side and the second
   // join restores the full mask.
   assign lo_entry = '{tmask: thread_masks[wid], pc: warp_ctl_if.split.next_pc, is_else: 1'b0};
   assign hi_entry = '{tmask: warp_ctl_if.split.else_tmask, pc: warp_ctl_if.split.next_pc, is_else: 1'b1};

   assign warp_ctl_if.dvstack_ptr = stack_ptrs[warp_ctl_if.dvstack_wid];

   // One IPDOM stack per warp; only the addressed warp ever sees push/pop.
   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_stack
      vx_warp_ctl_recv_ipdom_stack u_stack (
         .clk       (clk),
         .reset     (reset),
         .push2     (push2[w]),
         .lo_entry  (lo_entry),
         .hi_entry  (hi_entry),
         .pop       (pop[w]),
         .top_entry (top_entry[w]),
         .ptr       (stack_ptrs[w])
      );
   end

   // Next-state decode for the single request of this cycle. Everything
   // starts from the current registered values and only the fields the
   // request touches are overridden; pulses default low.
   always_comb begin
      active_n         = warp_active;
      masks_n          = thread_masks;
      stalled_n        = warp_stalled;
      bar_mask_n       = bar_mask;
      bar_cnt_n        = bar_cnt;
      redirect_valid_n = 1'b0;
      redirect_wid_n   = redirect_wid;
      redirect_pc_n    = redirect_pc;
      spawn_valid_n    = 1'b0;
      spawn_mask_n     = spawn_mask;
      spawn_pc_n       = spawn_pc;
      ovf_n            = dvstack_ovf;
      push2            = '0;
      pop              = '0;

      if (warp_ctl_if.valid) begin
         if (warp_ctl_if.tmc.valid) begin
            masks_n[wid] = warp_ctl_if.tmc.tmask;
            if (warp_ctl_if.tmc.tmask == '0) begin
               // A retiring warp must not keep a barrier waiting on it, so
               // it leaves every barrier it joined and the arrival count
               // drops with it.
               active_n[wid]  = 1'b0;
               stalled_n[wid] = 1'b0;
               for (int b = 0; b < NUM_BARRIERS; b++) begin
                  if (bar_mask[b][wid]) begin
                     bar_mask_n[b][wid] = 1'b0;
                     bar_cnt_n[b]       = bar_cnt[b] - NW_WIDTH'(1);
                  end
               end
            end
         end

         if (warp_ctl_if.wspawn.valid) begin
            active_n = warp_active | spawn_bits;
            for (int w = 1; w < NUM_WARPS; w++) begin
               if (spawn_bits[w]) begin
                  masks_n[w] = NUM_THREADS'(1);
               end
            end
            spawn_valid_n = 1'b1;
            spawn_mask_n  = spawn_bits;
            spawn_pc_n    = warp_ctl_if.wspawn.pc;
         end

         if (warp_ctl_if.split.valid && warp_ctl_if.split.is_dvg) begin
            if (can_push) begin
               push2[wid]   = 1'b1;
               masks_n[wid] = warp_ctl_if.split.then_tmask;
            end else begin
               ovf_n = 1'b1;
            end
         end

         // A join whose saved pointer already matches means the split it
         // pairs with was not divergent; nothing to pop.
         if (warp_ctl_if.sjoin.valid && (stack_ptrs[wid] != warp_ctl_if.sjoin.stack_ptr)
             && (stack_ptrs[wid] != '0)) begin
            pop[wid]     = 1'b1;
            masks_n[wid] = top_entry[wid].tmask;
            if (top_entry[wid].is_else) begin
               redirect_valid_n = 1'b1;
               redirect_wid_n   = wid;
               redirect_pc_n    = top_entry[wid].pc;
            end
         end

         if (warp_ctl_if.barrier.valid && !warp_ctl_if.barrier.is_noop
             && !warp_ctl_if.barrier.is_global) begin
            if (bar_cnt[warp_ctl_if.barrier.id] == warp_ctl_if.barrier.size_m1) begin
               // Last arrival: everyone waiting goes, and the arriving warp
               // never stalls.
               stalled_n                        = warp_stalled & ~bar_mask[warp_ctl_if.barrier.id];
               bar_mask_n[warp_ctl_if.barrier.id] = '0;
               bar_cnt_n[warp_ctl_if.barrier.id]  = '0;
            end else begin
               bar_mask_n[warp_ctl_if.barrier.id][wid] = 1'b1;
               bar_cnt_n[warp_ctl_if.barrier.id]       = bar_cnt[warp_ctl_if.barrier.id] + NW_WIDTH'(1);
               stalled_n[wid]                          = 1'b1;
            end
         end
      end
   end

   // State and output registers. Reset leaves only warp 0 running with a
   // single thread and wipes any in-flight barrier or pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         warp_active     <= NUM_WARPS'(1);
         thread_masks    <= '0;
         thread_masks[0] <= NUM_THREADS'(1);
         warp_stalled    <= '0;
         bar_mask        <= '0;
         bar_cnt         <= '0;
         redirect_valid  <= 1'b0;
         redirect_wid    <= '0;
         redirect_pc     <= '0;
         spawn_valid     <= 1'b0;
         spawn_mask      <= '0;
         spawn_pc        <= '0;
         dvstack_ovf     <= 1'b0;
      end else begin
         warp_active     <= active_n;
         thread_masks    <= masks_n;
         warp_stalled    <= stalled_n;
         bar_mask        <= bar_mask_n;
         bar_cnt         <= bar_cnt_n;
         redirect_valid  <= redirect_valid_n;
         redirect_wid    <= redirect_wid_n;
         redirect_pc     <= redirect_pc_n;
         spawn_valid     <= spawn_valid_n;
         spawn_mask      <= spawn_mask_n;
         spawn_pc        <= spawn_pc_n;
         dvstack_ovf     <= ovf_n;
      end
   end

`ifdef WCTL_PERF_EN
   // Event counters: divergent splits that actually pushed, joins that
   // produced a redirect, and warp-cycles spent stalled at barriers.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_splits           <= '0;
         perf_joins_redirect   <= '0;
         perf_bar_stall_cycles <= '0;
      end else begin
         perf_splits           <= perf_splits + PERF_CTR_BITS'(|push2);
         perf_joins_redirect   <= perf_joins_redirect + PERF_CTR_BITS'(redirect_valid);
         perf_bar_stall_cycles <= perf_bar_stall_cycles + PERF_CTR_BITS'(count_ones(warp_stalled));
      end
   end
`endif

   // Protocol checks on the request channel.
   assert property (@(posedge clk) disable iff (reset)
      warp_ctl_if.valid |-> $onehot0({warp_ctl_if.tmc.valid, warp_ctl_if.wspawn.valid,
                                      warp_ctl_if.split.valid, warp_ctl_if.sjoin.valid,
                                      warp_ctl_if.barrier.valid}));

   assert property (@(posedge clk) disable iff (reset)
      (warp_ctl_if.valid && warp_ctl_if.sjoin.valid && (stack_ptrs[wid] == '0))
         |-> (warp_ctl_if.sjoin.stack_ptr == '0));

   assert property (@(posedge clk) disable iff (reset)
      (warp_ctl_if.valid && warp_ctl_if.barrier.valid && !warp_ctl_if.barrier.is_noop)
         |-> !warp_ctl_if.barrier.is_global);

endmodule

// File: tb/tb_vx_warp_ctl_recv.sv
// ============================================================================
// tb_vx_warp_ctl_recv
// ----------------------------------------------------------------------------
// Directed bench for vx_warp_ctl_recv in its default build (4 warps,
// 4 threads, 8-entry divergence stacks). Requests are driven on the falling
// edge, captured on the rising edge, and results are read on the next
// falling edge.
// ============================================================================

module tb_vx_warp_ctl_recv;
   import vx_warp_ctl_recv_pkg::*;

   logic                                  clk;
   logic                                  reset;
   logic [NUM_WARPS-1:0]                  warp_active;
   logic [NUM_WARPS-1:0][NUM_THREADS-1:0] thread_masks;
   logic [NUM_WARPS-1:0]                  warp_stalled;
   logic                                  redirect_valid;
   logic [NW_WIDTH-1:0]                   redirect_wid;
   logic [PC_BITS-1:0]                    redirect_pc;
   logic                                  spawn_valid;
   logic [NUM_WARPS-1:0]                  spawn_mask;
   logic [PC_BITS-1:0]                    spawn_pc;
   logic                                  dvstack_ovf;

   int checkCount = 0;
   int passCount  = 0;

   vx_warp_ctl_recv_if ctl_if ();

   vx_warp_ctl_recv dut (
      .clk            (clk),
      .reset          (reset),
      .warp_ctl_if    (ctl_if.slave),
      .warp_active    (warp_active),
      .thread_masks   (thread_masks),
      .warp_stalled   (warp_stalled),
      .redirect_valid (redirect_valid),
      .redirect_wid   (redirect_wid),
      .redirect_pc    (redirect_pc),
      .spawn_valid    (spawn_valid),
      .spawn_mask     (spawn_mask),
      .spawn_pc       (spawn_pc),
      .dvstack_ovf    (dvstack_ovf)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clearBus();
      ctl_if.valid   = 1'b0;
      ctl_if.wid     = '0;
      ctl_if.tmc     = '0;
      ctl_if.wspawn  = '0;
      ctl_if.split   = '0;
      ctl_if.sjoin   = '0;
      ctl_if.barrier = '0;
   endtask

   task automatic startReq(input int w);
      @(negedge clk);
      clearBus();
      ctl_if.valid = 1'b1;
      ctl_if.wid   = NW_WIDTH'(w);
   endtask

   // Ends the request set up by startReq: returns on the falling edge just
   // after the rising edge that consumed it, with the bus idle again.
   task automatic applyStimulus();
      @(negedge clk);
      clearBus();
   endtask

   task automatic sendTmc(input int w, input logic [NUM_THREADS-1:0] tmask);
      startReq(w);
      ctl_if.tmc.valid = 1'b1;
      ctl_if.tmc.tmask = tmask;
      applyStimulus();
   endtask

   task automatic sendWspawn(input logic [NUM_WARPS-1:0] wmask, input logic [PC_BITS-1:0] pc);
      startReq(0);
      ctl_if.wspawn.valid = 1'b1;
      ctl_if.wspawn.wmask = wmask;
      ctl_if.wspawn.pc    = pc;
      applyStimulus();
   endtask

   task automatic sendSplit(input int w, input logic dvg, input logic [NUM_THREADS-1:0] then_m,
                            input logic [NUM_THREADS-1:0] else_m, input logic [PC_BITS-1:0] pc);
      startReq(w);
      ctl_if.split.valid      = 1'b1;
      ctl_if.split.is_dvg     = dvg;
      ctl_if.split.then_tmask = then_m;
      ctl_if.split.else_tmask = else_m;
      ctl_if.split.next_pc    = pc;
      applyStimulus();
   endtask

   task automatic sendJoin(input int w, input int sptr);
      startReq(w);
      ctl_if.sjoin.valid     = 1'b1;
      ctl_if.sjoin.stack_ptr = DV_STACK_SIZEW'(sptr);
      applyStimulus();
   endtask

   task automatic sendBarrier(input int w, input int id, input int size_m1);
      startReq(w);
      ctl_if.barrier.valid   = 1'b1;
      ctl_if.barrier.id      = NB_WIDTH'(id);
      ctl_if.barrier.size_m1 = NW_WIDTH'(size_m1);
      applyStimulus();
   endtask

   task automatic checkPtr(input string tag, input int w, input int expected);
      ctl_if.dvstack_wid = NW_WIDTH'(w);
      #1;
      checkOutput(tag, 64'(ctl_if.dvstack_ptr), 64'(expected));
   endtask

   task automatic doReset();
      @(negedge clk);
      clearBus();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      clearBus();
      ctl_if.dvstack_wid = '0;
      doReset();

      // Reset state.
      checkOutput("rst_active", 64'(warp_active), 64'h1);
      checkOutput("rst_masks", 64'(thread_masks), 64'h0001);
      checkOutput("rst_stalled", 64'(warp_stalled), 64'h0);
      checkOutput("rst_ovf", 64'(dvstack_ovf), 64'h0);
      checkOutput("rst_redirect", 64'(redirect_valid), 64'h0);
      for (int w = 0; w < NUM_WARPS; w++) checkPtr($sformatf("rst_ptr%0d", w), w, 0);

      // Spawn warps 1..3 at 0x8000_0100; each starts with thread 0 only.
      sendWspawn(4'hF, 32'h8000_0100);
      checkOutput("spawn_active", 64'(warp_active), 64'hF);
      checkOutput("spawn_valid", 64'(spawn_valid), 64'h1);
      checkOutput("spawn_pc", 64'(spawn_pc), 64'h8000_0100);
      checkOutput("spawn_mask", 64'(spawn_mask), 64'hE);
      checkOutput("spawn_masks", 64'(thread_masks), 64'h1111);
      @(negedge clk);
      checkOutput("spawn_pulse_end", 64'(spawn_valid), 64'h0);

      // Divergent split / two joins on warp 0.
      sendTmc(0, 4'hF);
      checkOutput("tmc_masks", 64'(thread_masks), 64'h111F);
      sendSplit(0, 1'b1, 4'h3, 4'hC, 32'h80);
      checkOutput("split_masks", 64'(thread_masks), 64'h1113);
      checkPtr("split_ptr", 0, 2);
      checkOutput("split_noredir", 64'(redirect_valid), 64'h0);
      sendJoin(0, 0);
      checkOutput("join1_masks", 64'(thread_masks), 64'h111C);
      checkOutput("join1_redir", 64'(redirect_valid), 64'h1);
      checkOutput("join1_pc", 64'(redirect_pc), 64'h80);
      checkOutput("join1_wid", 64'(redirect_wid), 64'h0);
      checkPtr("join1_ptr", 0, 1);
      sendJoin(0, 0);
      checkOutput("join2_masks", 64'(thread_masks), 64'h111F);
      checkOutput("join2_redir", 64'(redirect_valid), 64'h0);
      checkPtr("join2_ptr", 0, 0);

      // Uniform split then matching join: nothing changes.
      sendSplit(1, 1'b0, 4'h1, 4'h0, 32'h200);
      checkOutput("nsplit_masks", 64'(thread_masks), 64'h111F);
      checkPtr("nsplit_ptr", 1, 0);
      sendJoin(1, 0);
      checkOutput("njoin_masks", 64'(thread_masks), 64'h111F);
      checkOutput("njoin_redir", 64'(redirect_valid), 64'h0);
      checkPtr("njoin_ptr", 1, 0);

      // Barrier 0 for three warps.
      sendBarrier(0, 0, 2);
      checkOutput("bar_w0", 64'(warp_stalled), 64'h1);
      sendBarrier(1, 0, 2);
      checkOutput("bar_w1", 64'(warp_stalled), 64'h3);
      sendBarrier(2, 0, 2);
      checkOutput("bar_release", 64'(warp_stalled), 64'h0);

      // Single-warp barrier releases on arrival.
      sendBarrier(3, 1, 0);
      checkOutput("bar_single", 64'(warp_stalled), 64'h0);

      // A stalled warp retired by tmc drops its stall.
      sendBarrier(3, 2, 1);
      checkOutput("bar_w3", 64'(warp_stalled), 64'h8);
      sendTmc(3, 4'h0);
      checkOutput("tmc0_active", 64'(warp_active), 64'h7);
      checkOutput("tmc0_stalled", 64'(warp_stalled), 64'h0);
      checkOutput("tmc0_masks", 64'(thread_masks), 64'h011F);

      // Fill warp 1's stack exactly, pop once to leave 7, then overflow.
      for (int i = 0; i < 4; i++) sendSplit(1, 1'b1, 4'h1, 4'h2, 32'h300);
      checkPtr("full_ptr", 1, 8);
      checkOutput("full_noovf", 64'(dvstack_ovf), 64'h0);
      sendJoin(1, 0);
      checkPtr("pop7_ptr", 1, 7);
      checkOutput("pop7_masks", 64'(thread_masks), 64'h012F);
      checkOutput("pop7_pc", 64'(redirect_pc), 64'h300);
      sendSplit(1, 1'b1, 4'h1, 4'h2, 32'h400);
      checkPtr("ovf_ptr", 1, 7);
      checkOutput("ovf_masks", 64'(thread_masks), 64'h012F);
      checkOutput("ovf_flag", 64'(dvstack_ovf), 64'h1);
      @(negedge clk);
      checkOutput("ovf_sticky", 64'(dvstack_ovf), 64'h1);

      // Reset in the middle of everything discards all state.
      doReset();
      checkOutput("rst2_active", 64'(warp_active), 64'h1);
      checkOutput("rst2_masks", 64'(thread_masks), 64'h0001);
      checkOutput("rst2_ovf", 64'(dvstack_ovf), 64'h0);
      checkPtr("rst2_ptr1", 1, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
